wb_stage_skid_reg: RTL and testbench



---
 rtl/wb_pipe_pkg.sv | 36 +++
 rtl/wb_stage_ctrl.sv | 84 ++++++++
 rtl/wb_stage_skid_reg.sv | 113 +++++++++++
 tb/tb_wb_stage_skid_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_pipe_pkg
// Shared types and constants for the Memory->Writeback pipeline boundary.
//   XLEN, NUM_OPS, SRC_W, RD_W : default bundle field widths
//   RES_*                      : result-select encodings
//   wb_bundle_t                : {result_src, reg_write, rd, ops}
//   wb_state_e                 : boundary-register occupancy states
// Related build macro: WB_X0_SUPPRESS_EN (used by wb_stage_skid_reg).
// -----------------------------------------------------------------------------
package wb_pipe_pkg;

   localparam int XLEN    = 32;
   localparam int NUM_OPS = 5;
   localparam int SRC_W   = 3;
   localparam int RD_W    = 5;

   localparam logic [SRC_W-1:0] RES_ALU   = 3'd0;
   localparam logic [SRC_W-1:0] RES_MEM   = 3'd1;
   localparam logic [SRC_W-1:0] RES_PC4   = 3'd2;
   localparam logic [SRC_W-1:0] RES_IMM   = 3'd3;
   localparam logic [SRC_W-1:0] RES_PCIMM = 3'd4;

   typedef struct packed {
      logic [SRC_W-1:0]        result_src;
      logic                    reg_write;
      logic [RD_W-1:0]         rd;
      logic [NUM_OPS*XLEN-1:0] ops;
   } wb_bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_stage_ctrl.sv
// -----------------------------------------------------------------------------
// wb_stage_ctrl
// Occupancy FSM for the Memory->Writeback skid register.
//   CLK, RST     : clock, synchronous active-high reset
//   flush        : drop everything, next state EMPTY
//   acc, drn     : upstream accept / downstream drain this cycle
//   load_out     : capture incoming bundle into OUT
//   load_skd     : capture incoming bundle into SKD
//   out_from_skd : move SKD into OUT
//   ready_M      : registered, low only in SKID
//   valid_W      : registered, high unless EMPTY
// -----------------------------------------------------------------------------
module wb_stage_ctrl
   import wb_pipe_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic flush,
   input  logic acc,
   input  logic drn,
   output logic load_out,
   output logic load_skd,
   output logic out_from_skd,
   output logic ready_M,
   output logic valid_W
);

   wb_state_e state;
   wb_state_e state_nxt;

   always_comb begin
      state_nxt    = state;
      load_out     = 1'b0;
      load_skd     = 1'b0;
      out_from_skd = 1'b0;
      unique case (state)
         EMPTY: begin
            if (acc) begin
               load_out  = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (acc && drn) begin
               load_out = 1'b1;
            end else if (acc) begin
               load_skd  = 1'b1;
               state_nxt = SKID;
            end else if (drn) begin
               state_nxt = EMPTY;
            end
         end
         SKID: begin
            if (drn) begin
               out_from_skd = 1'b1;
               state_nxt    = FULL;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush discards both held bundles and anything arriving this cycle.
      if (flush) begin
         load_out     = 1'b0;
         load_skd     = 1'b0;
         out_from_skd = 1'b0;
         state_nxt    = EMPTY;
      end
   end

   // Handshake outputs are registered from the next state so ready_M never
   // depends combinationally on ready_W.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= EMPTY;
         ready_M <= 1'b1;
         valid_W <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_M <= (state_nxt != SKID);
         valid_W <= (state_nxt != EMPTY);
      end
   end

endmodule

// File: rtl/wb_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_skid_reg
// Memory->Writeback boundary register with valid/ready handshake and a
// one-entry skid buffer; ready_M is purely registered.
//   CLK, RST                                   : clock, sync active-high reset
//   flush                                      : discard held/incoming bundles
//   valid_M, ready_M                           : upstream handshake
//   result_src_M, reg_write_M, rd_M, ops_M     : incoming bundle
//   valid_W, ready_W                           : downstream handshake
//   result_src_W, reg_write_W, rd_W, ops_W     : registered bundle
// Build macro WB_X0_SUPPRESS_EN: when defined, a bundle captured with rd==0
// stores reg_write=0 so writeback never sees a write to x0.
// -----------------------------------------------------------------------------
module wb_stage_skid_reg #(
   parameter int XLEN    = 32,
   parameter int NUM_OPS = 5,
   parameter int SRC_W   = 3,
   parameter int RD_W    = 5
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    flush,
   input  logic                    valid_M,
   output logic                    ready_M,
   input  logic [SRC_W-1:0]        result_src_M,
   input  logic                    reg_write_M,
   input  logic [RD_W-1:0]         rd_M,
   input  logic [NUM_OPS*XLEN-1:0] ops_M,
   output logic                    valid_W,
   input  logic                    ready_W,
   output logic [SRC_W-1:0]        result_src_W,
   output logic                    reg_write_W,
   output logic [RD_W-1:0]         rd_W,
   output logic [NUM_OPS*XLEN-1:0] ops_W
);

   import wb_pipe_pkg::*;

   // Same layout as wb_bundle_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [SRC_W-1:0]        result_src;
      logic                    reg_write;
      logic [RD_W-1:0]         rd;
      logic [NUM_OPS*XLEN-1:0] ops;
   } bundle_t;

   logic    acc;
   logic    drn;
   logic    load_out;
   logic    load_skd;
   logic    out_from_skd;
   logic    we_cap;
   bundle_t in_b;
   bundle_t out_q;
   bundle_t skd_q;

   assign acc = valid_M & ready_M;
   assign drn = valid_W & ready_W;

`ifdef WB_X0_SUPPRESS_EN
   assign we_cap = reg_write_M & (rd_M != '0);
`else
   assign we_cap = reg_write_M;
`endif

   always_comb begin
      in_b            = '0;
      in_b.result_src = result_src_M;
      in_b.reg_write  = we_cap;
      in_b.rd         = rd_M;
      in_b.ops        = ops_M;
   end

   wb_stage_ctrl u_ctrl (
      .CLK          (CLK),
      .RST          (RST),
      .flush        (flush),
      .acc          (acc),
      .drn          (drn),
      .load_out     (load_out),
      .load_skd     (load_skd),
      .out_from_skd (out_from_skd),
      .ready_M      (ready_M),
      .valid_W      (valid_W)
   );

   // Memory -> Writeback boundary: OUT and SKD slots
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_q <= '0;
         skd_q <= '0;
      end else if (flush) begin
         // Payload stays stale; only the write request is killed.
         out_q.reg_write <= 1'b0;
         skd_q.reg_write <= 1'b0;
      end else begin
         if (load_out) begin
            out_q <= in_b;
         end else if (out_from_skd) begin
            out_q <= skd_q;
         end
         if (load_skd) begin
            skd_q <= in_b;
         end
      end
   end

   assign result_src_W = out_q.result_src;
   assign reg_write_W  = out_q.reg_write & valid_W;
   assign rd_W         = out_q.rd;
   assign ops_W        = out_q.ops;

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
module tb_wb_stage_skid_reg;

   localparam int OPW = 160;

   typedef struct {
      logic [2:0]     src;
      logic           rw;
      logic [4:0]     rd;
      logic [OPW-1:0] ops;
   } bnd_t;

   logic           CLK = 1'b0;
   logic           RST;
   logic           flush;
   logic           valid_M;
   logic           ready_M;
   logic [2:0]     result_src_M;
   logic           reg_write_M;
   logic [4:0]     rd_M;
   logic [OPW-1:0] ops_M;
   logic           valid_W;
   logic           ready_W;
   logic [2:0]     result_src_W;
   logic           reg_write_W;
   logic [4:0]     rd_W;
   logic [OPW-1:0] ops_W;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: FIFO of at most two bundles; head is what writeback sees.
   bnd_t q[$];
   bit   zero_out = 1'b1;

   always #5 CLK = ~CLK;

   wb_stage_skid_reg dut (
      .CLK          (CLK),
      .RST          (RST),
      .flush        (flush),
      .valid_M      (valid_M),
      .ready_M      (ready_M),
      .result_src_M (result_src_M),
      .reg_write_M  (reg_write_M),
      .rd_M         (rd_M),
      .ops_M        (ops_M),
      .valid_W      (valid_W),
      .ready_W      (ready_W),
      .result_src_W (result_src_W),
      .reg_write_W  (reg_write_W),
      .rd_W         (rd_W),
      .ops_W        (ops_W)
   );

   task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bnd_t mk(input logic [4:0] rd, input logic rw);
      bnd_t b;
      b.src = 3'($urandom_range(0, 4));
      b.rw  = rw;
      b.rd  = rd;
      for (int k = 0; k < OPW / 32; k++) b.ops[k*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic exp_we(input bnd_t b);
`ifdef WB_X0_SUPPRESS_EN
      return b.rw && (b.rd != 5'd0);
`else
      return b.rw;
`endif
   endfunction

   task automatic check_outputs();
      chk("valid_W", valid_W, q.size() != 0);
      chk("ready_M", ready_M, q.size() < 2);
      if (q.size() != 0) begin
         chk("rd_W", rd_W, q[0].rd);
         chk("result_src_W", result_src_W, q[0].src);
         chk("ops_W", ops_W, q[0].ops);
         chk("reg_write_W", reg_write_W, exp_we(q[0]));
      end else begin
         chk("reg_write_W_bubble", reg_write_W, 1'b0);
         if (zero_out) begin
            chk("rd_W_rst", rd_W, 5'd0);
            chk("result_src_W_rst", result_src_W, 3'd0);
            chk("ops_W_rst", ops_W, '0);
         end
      end
   endtask

   // One clock: drive inputs, check outputs at negedge, advance model at posedge.
   task automatic step(input logic v, input bnd_t b, input logic rdy,
                       input logic fl, input logic rs);
      bit m_acc;
      bit m_drn;
      valid_M      = v;
      result_src_M = b.src;
      reg_write_M  = b.rw;
      rd_M         = b.rd;
      ops_M        = b.ops;
      ready_W      = rdy;
      flush        = fl;
      RST          = rs;
      @(negedge CLK);
      check_outputs();
      m_acc = v && (q.size() < 2);
      m_drn = (q.size() != 0) && rdy;
      @(posedge CLK);
      if (rs) begin
         q.delete();
         zero_out = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         if (m_drn) void'(q.pop_front());
         if (m_acc) begin
            q.push_back(b);
            zero_out = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      bnd_t b;
      RST = 1'b1; flush = 1'b0; valid_M = 1'b1; ready_W = 1'b1;
      result_src_M = 3'd5; reg_write_M = 1'b1; rd_M = 5'd7; ops_M = '1;
      @(posedge CLK); #1;

      // Reset held two more cycles with valid_M high
      step(1'b1, mk(5'd7, 1'b1), 1'b1, 1'b0, 1'b1);
      step(1'b1, mk(5'd7, 1'b1), 1'b1, 1'b0, 1'b1);

      // Streaming rd=1..8 with ready_W high
      for (int i = 1; i <= 8; i++) step(1'b1, mk(5'(i), 1'b1), 1'b1, 1'b0, 1'b0);
      chk("stream_last_rd", rd_W, 5'd8);
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);

      // Back-pressure: A(rd=3), B(rd=4) with ready_W low
      step(1'b1, mk(5'd3, 1'b1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(5'd4, 1'b1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(5'd9, 1'b1), 1'b0, 1'b0, 1'b0);
      chk("bp_ready_low", ready_M, 1'b0);
      chk("bp_rd_hold", rd_W, 5'd3);
      step(1'b0, mk(5'd0, 1'b0), 1'b0, 1'b0, 1'b0);
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
      chk("bp_rd_B", rd_W, 5'd4);
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);

      // Flush in SKID with a new bundle arriving
      step(1'b1, mk(5'd10, 1'b1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(5'd11, 1'b1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(5'd12, 1'b1), 1'b0, 1'b1, 1'b0);
      chk("flush_valid", valid_W, 1'b0);
      chk("flush_we", reg_write_W, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, mk(5'd0, 1'b1), 1'b1, 1'b0, 1'b0);

      // Bubble with reg_write_M high
      for (int i = 0; i < 3; i++) step(1'b0, mk(5'd6, 1'b1), 1'b1, 1'b0, 1'b0);

      // x0 write request
      step(1'b1, mk(5'd0, 1'b1), 1'b1, 1'b0, 1'b0);
`ifdef WB_X0_SUPPRESS_EN
      chk("x0_we", reg_write_W, 1'b0);
`else
      chk("x0_we", reg_write_W, 1'b1);
`endif
      step(1'b0, mk(5'd0, 1'b0), 1'b1, 1'b0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         b = mk(5'($urandom_range(0, 7)), 1'($urandom));
         step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
